// File: rtl/indianpoker_pkg.sv
// Shared constants for the Indian poker round controller: states, phase codes,
// result encodings and responder actions.
package indianpoker_pkg;

  localparam int unsigned CARD_W  = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_DEAL = 3'd1;
  localparam logic [STATE_W-1:0] ST_ANTE = 3'd2;
  localparam logic [STATE_W-1:0] ST_BET  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP = 3'd4;
  localparam logic [STATE_W-1:0] ST_SHOW = 3'd5;
  localparam logic [STATE_W-1:0] ST_OVER = 3'd6;

  localparam logic [1:0] PH_DEAL = 2'b00;
  localparam logic [1:0] PH_P1   = 2'b01;
  localparam logic [1:0] PH_P2   = 2'b10;
  localparam logic [1:0] PH_SHOW = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic ACT_FOLD = 1'b0;
  localparam logic ACT_CALL = 1'b1;

  // Whose turn it is: bettor acts in BET, the other player in RESP.
  function automatic logic [1:0] phase_of(input logic [STATE_W-1:0] st, input logic p2_bets);
    logic [1:0] ph;
    ph = PH_DEAL;
    case (st)
      ST_BET:           ph = p2_bets ? PH_P2 : PH_P1;
      ST_RESP:          ph = p2_bets ? PH_P1 : PH_P2;
      ST_SHOW, ST_OVER: ph = PH_SHOW;
      default:          ph = PH_DEAL;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/indianpoker_btn_edge.sv
// Rising-edge step generator for one button; with INDIANPOKER_AUTOREPEAT_EN
// defined, a held button also repeats every REPEAT_DLY cycles.
module indianpoker_btn_edge
  import indianpoker_pkg::*;
`ifdef INDIANPOKER_AUTOREPEAT_EN
#(
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = 8
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic step_c
);

  logic hist;

  // History resets as "already pressed" so a button held through reset gives no step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 1'b1;
    else     hist <= x;
  end

`ifdef INDIANPOKER_AUTOREPEAT_EN
  logic rpt_c;

  if (REPEAT_EN) begin : g_rpt
    localparam int unsigned CNT_W = $clog2(REPEAT_DLY + 1);
    logic [CNT_W-1:0] cnt;

    // Counts held cycles since the last step; restarts on every step or release.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                         cnt <= '0;
      else if (!x || !hist || rpt_c)   cnt <= '0;
      else                             cnt <= cnt + CNT_W'(1);
    end

    assign rpt_c = x && hist && (cnt == CNT_W'(REPEAT_DLY - 1));
  end else begin : g_norpt
    assign rpt_c = 1'b0;
  end

  assign step_c = (x && !hist) || rpt_c;
`else
  assign step_c = x && !hist;
`endif

endmodule

// File: rtl/indianpoker_round_ctrl.sv
// Indian poker round sequencer: deal, ante, bet, respond, settle, repeat until a
// stack empties. Optional Up/Down autorepeat via INDIANPOKER_AUTOREPEAT_EN.
module indianpoker_round_ctrl
  import indianpoker_pkg::*;
#(
  parameter int unsigned CHIP_W     = 8,
  parameter int unsigned INIT_CHIPS = 20,
  parameter int unsigned REPEAT_DLY = 8
)
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              set,
  input  logic              Up,
  input  logic              Down,
  output logic              deal_req,
  input  logic              deal_vld,
  input  logic [CARD_W-1:0] card1,
  input  logic [CARD_W-1:0] card2,
  output logic [CARD_W-1:0] c1,
  output logic [CARD_W-1:0] c2,
  output logic              Q1,
  output logic              Q0,
  output logic [CHIP_W-1:0] b,
  output logic              a,
  output logic [CHIP_W-1:0] pot,
  output logic [CHIP_W-1:0] s1,
  output logic [CHIP_W-1:0] s2,
  output logic [1:0]        win,
  output logic              over
);

  logic set_step_c, up_step_c, down_step_c;

  indianpoker_btn_edge u_set (.clk(CLK), .rst(CLR), .x(set), .step_c(set_step_c));

`ifdef INDIANPOKER_AUTOREPEAT_EN
  indianpoker_btn_edge #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY))
    u_up   (.clk(CLK), .rst(CLR), .x(Up),   .step_c(up_step_c));
  indianpoker_btn_edge #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY))
    u_down (.clk(CLK), .rst(CLR), .x(Down), .step_c(down_step_c));
`else
  indianpoker_btn_edge u_up   (.clk(CLK), .rst(CLR), .x(Up),   .step_c(up_step_c));
  indianpoker_btn_edge u_down (.clk(CLK), .rst(CLR), .x(Down), .step_c(down_step_c));
`endif

  logic [STATE_W-1:0] state, state_nxt;
  logic               p2_bets, p2_bets_nxt;
  logic [CHIP_W-1:0]  s1_nxt, s2_nxt, pot_nxt, b_nxt;
  logic [CARD_W-1:0]  c1_nxt, c2_nxt;
  logic               a_nxt, deal_req_nxt, over_nxt;
  logic [1:0]         win_nxt, q, q_nxt, winner_c;
  logic [CHIP_W-1:0]  cap_c;

  assign cap_c = (s1 < s2) ? s1 : s2;
  assign Q1    = q[1];
  assign Q0    = q[0];

  // State and datapath registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= ST_IDLE;
      p2_bets  <= 1'b0;
      s1       <= CHIP_W'(INIT_CHIPS);
      s2       <= CHIP_W'(INIT_CHIPS);
      pot      <= '0;
      b        <= '0;
      a        <= 1'b0;
      c1       <= '0;
      c2       <= '0;
      win      <= WIN_NONE;
      over     <= 1'b0;
      deal_req <= 1'b0;
      q        <= PH_DEAL;
    end else begin
      state    <= state_nxt;
      p2_bets  <= p2_bets_nxt;
      s1       <= s1_nxt;
      s2       <= s2_nxt;
      pot      <= pot_nxt;
      b        <= b_nxt;
      a        <= a_nxt;
      c1       <= c1_nxt;
      c2       <= c2_nxt;
      win      <= win_nxt;
      over     <= over_nxt;
      deal_req <= deal_req_nxt;
      q        <= q_nxt;
    end
  end

  // Next-state and next-datapath logic; button priority is set > Up > Down.
  always_comb begin
    state_nxt    = state;
    p2_bets_nxt  = p2_bets;
    s1_nxt       = s1;
    s2_nxt       = s2;
    pot_nxt      = pot;
    b_nxt        = b;
    a_nxt        = a;
    c1_nxt       = c1;
    c2_nxt       = c2;
    win_nxt      = win;
    deal_req_nxt = 1'b0;
    winner_c     = WIN_NONE;

    case (state)
      ST_IDLE: begin
        if (set_step_c) state_nxt = ST_DEAL;
      end
      ST_DEAL: begin
        if (deal_vld) begin
          c1_nxt    = card1;
          c2_nxt    = card2;
          state_nxt = ST_ANTE;
        end else begin
          deal_req_nxt = 1'b1;
        end
      end
      ST_ANTE: begin
        s1_nxt  = s1 - CHIP_W'(1);
        s2_nxt  = s2 - CHIP_W'(1);
        pot_nxt = pot + CHIP_W'(2);
        // A player left with nothing to bet forces an immediate showdown.
        if (cap_c == CHIP_W'(1)) begin
          b_nxt     = '0;
          a_nxt     = ACT_CALL;
          state_nxt = ST_SHOW;
        end else begin
          b_nxt     = CHIP_W'(1);
          state_nxt = ST_BET;
        end
      end
      ST_BET: begin
        if (set_step_c) begin
          a_nxt     = ACT_CALL;
          state_nxt = ST_RESP;
        end else if (up_step_c) begin
          if (b < cap_c) b_nxt = b + CHIP_W'(1);
        end else if (down_step_c) begin
          if (b > CHIP_W'(1)) b_nxt = b - CHIP_W'(1);
        end
      end
      ST_RESP: begin
        if (set_step_c) begin
          if (a == ACT_CALL) begin
            s1_nxt  = s1 - b;
            s2_nxt  = s2 - b;
            pot_nxt = pot + (b << 1);
          end
          state_nxt = ST_SHOW;
        end else if (up_step_c) begin
          a_nxt = ACT_CALL;
        end else if (down_step_c) begin
          a_nxt = ACT_FOLD;
        end
      end
      ST_SHOW: begin
        if (a == ACT_FOLD)  winner_c = p2_bets ? WIN_P2 : WIN_P1;
        else if (c1 > c2)   winner_c = WIN_P1;
        else if (c2 > c1)   winner_c = WIN_P2;
        else                winner_c = WIN_TIE;
        case (winner_c)
          WIN_P1:  s1_nxt = s1 + pot;
          WIN_P2:  s2_nxt = s2 + pot;
          default: begin
            s1_nxt = s1 + (pot >> 1);
            s2_nxt = s2 + (pot >> 1);
          end
        endcase
        pot_nxt     = '0;
        win_nxt     = winner_c;
        p2_bets_nxt = ~p2_bets;
        state_nxt   = (s1_nxt == '0 || s2_nxt == '0) ? ST_OVER : ST_DEAL;
      end
      ST_OVER: begin
        state_nxt = ST_OVER;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    over_nxt = (state_nxt == ST_OVER);
    q_nxt    = phase_of(state_nxt, p2_bets_nxt);
  end

endmodule
